// File: rtl/lsu.sv
`default_nettype none
// ============================================================================
// Module   : lsu
// Purpose  : RV32I load/store unit. Accepts one load or store at a time,
//            rejects illegal or misaligned requests locally, otherwise runs
//            a single memory access with an ack/err/timeout handshake and
//            returns a one-cycle response with formatted load data.
// Revision : 1.0  initial release
// ============================================================================
module lsu #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            req_valid,
    output logic            req_ready,
    input  logic            is_store,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] wdata,

    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic [1:0]      resp_err,

    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [3:0]      dmem_be,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_ack,
    input  logic [XLEN-1:0] dmem_rdata,
    input  logic            dmem_err
);

    localparam logic [1:0] c_err_ok    = 2'b00;
    localparam logic [1:0] c_err_align = 2'b01;
    localparam logic [1:0] c_err_fault = 2'b10;
    localparam logic [1:0] c_err_ill   = 2'b11;
    localparam logic [7:0] c_cnt_last  = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic            r_is_store;
    logic [2:0]      r_funct3;
    logic [1:0]      r_off;
    logic [7:0]      r_cnt;

    logic            w_accept;
    logic            w_illegal;
    logic            w_misaligned;
    logic [1:0]      w_size;
    logic [3:0]      w_be;
    logic [XLEN-1:0] w_wdata_rep;
    logic            w_timeout;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [XLEN-1:0] w_load_data;

    assign req_ready = (r_state == S_IDLE);
    assign w_accept  = req_valid && req_ready;
    assign w_timeout = (r_cnt == c_cnt_last);

    // Request decode: legality, alignment, lane mask and replicated store data
    always_comb begin
        w_size       = funct3[1:0];
        w_illegal    = is_store ? (funct3 > 3'd2)
                                : ((funct3 == 3'd3) || (funct3[2:1] == 2'b11));
        w_misaligned = ((w_size == 2'd1) && addr[0]) ||
                       ((w_size == 2'd2) && (addr[1:0] != 2'b00));
        w_be         = 4'b1111;
        w_wdata_rep  = wdata;
        case (w_size)
            2'd0: begin
                w_be        = 4'b0001 << addr[1:0];
                w_wdata_rep = {4{wdata[7:0]}};
            end
            2'd1: begin
                w_be        = 4'b0011 << addr[1:0];
                w_wdata_rep = {2{wdata[15:0]}};
            end
            default: begin
                w_be        = 4'b1111;
                w_wdata_rep = wdata;
            end
        endcase
    end

    // Load formatting: pick the addressed lane and extend per the latched width code
    always_comb begin
        w_byte      = dmem_rdata[{r_off, 3'b000} +: 8];
        w_half      = r_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        w_load_data = dmem_rdata;
        case (r_funct3)
            3'd0:    w_load_data = {{(XLEN-8){w_byte[7]}}, w_byte};
            3'd1:    w_load_data = {{(XLEN-16){w_half[15]}}, w_half};
            3'd4:    w_load_data = {{(XLEN-8){1'b0}}, w_byte};
            3'd5:    w_load_data = {{(XLEN-16){1'b0}}, w_half};
            default: w_load_data = dmem_rdata;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_state_nxt = (w_illegal || w_misaligned) ? S_RESP : S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (dmem_err || dmem_ack || w_timeout) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Request latch, memory-side outputs, wait counter and response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_is_store <= 1'b0;
            r_funct3   <= 3'd0;
            r_off      <= 2'd0;
            r_cnt      <= 8'd0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_be    <= 4'b0000;
            dmem_wdata <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= c_err_ok;
        end else begin
            resp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_is_store <= is_store;
                        r_funct3   <= funct3;
                        r_off      <= addr[1:0];
                        if (w_illegal) begin
                            resp_valid <= 1'b1;
                            resp_err   <= c_err_ill;
                            resp_rdata <= '0;
                        end else if (w_misaligned) begin
                            resp_valid <= 1'b1;
                            resp_err   <= c_err_align;
                            resp_rdata <= '0;
                        end else begin
                            r_cnt      <= 8'd0;
                            dmem_req   <= 1'b1;
                            dmem_we    <= is_store;
                            dmem_addr  <= {addr[XLEN-1:2], 2'b00};
                            dmem_be    <= w_be;
                            dmem_wdata <= w_wdata_rep;
                        end
                    end
                end
                S_ACCESS: begin
                    if (dmem_err) begin
                        dmem_req   <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_err   <= c_err_fault;
                        resp_rdata <= '0;
                    end else if (dmem_ack) begin
                        dmem_req   <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_err   <= c_err_ok;
                        resp_rdata <= r_is_store ? '0 : w_load_data;
                    end else if (w_timeout) begin
                        dmem_req   <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_err   <= c_err_fault;
                        resp_rdata <= '0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: begin
                    resp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu
// Purpose  : Self-checking bench for lsu: directed scenarios followed by
//            random loads/stores against an arithmetic reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_lsu;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_err;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        dmem_err;

    int n_checks = 0;
    int n_errors = 0;

    lsu #(.XLEN(32), .TIMEOUT(TO)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .is_store   (is_store),
        .funct3     (funct3),
        .addr       (addr),
        .wdata      (wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_be    (dmem_be),
        .dmem_wdata (dmem_wdata),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata),
        .dmem_err   (dmem_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // One complete transaction; ack_cyc / err_cyc are 1-based ACCESS cycles, 0 = never
    task automatic do_req(input logic st, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rd,
                          input int ack_cyc, input int err_cyc);
        int          off, nbytes, term;
        bit          illegal, mis, fault;
        logic [31:0] exp_be, exp_wd, exp_rd, lane;
        logic [1:0]  exp_err;

        off     = int'(a % 4);
        illegal = st ? (f > 2) : (f == 3 || f >= 6);
        nbytes  = (f % 4 == 0) ? 1 : (f % 4 == 1) ? 2 : 4;
        mis     = (nbytes == 2 && (a % 2) != 0) || (nbytes == 4 && off != 0);
        exp_be  = (nbytes == 4) ? 32'hF : ((32'(1) << nbytes) - 1) << off;
        exp_wd  = (nbytes == 1) ? (wd % 256) * 32'h0101_0101 :
                  (nbytes == 2) ? (wd % 65536) * 32'h0001_0001 : wd;

        term  = TO;
        fault = 1;
        if (ack_cyc != 0 && ack_cyc <= term) begin term = ack_cyc; fault = 0; end
        if (err_cyc != 0 && err_cyc <= term) begin term = err_cyc; fault = 1; end

        if (nbytes == 1) begin
            lane   = (rd >> (8 * off)) % 256;
            exp_rd = (f < 4 && lane >= 128) ? lane - 256 : lane;
        end else if (nbytes == 2) begin
            lane   = (rd >> (16 * (off / 2))) % 65536;
            exp_rd = (f < 4 && lane >= 32768) ? lane - 65536 : lane;
        end else begin
            exp_rd = rd;
        end

        @(negedge clk);
        check("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1; is_store = st; funct3 = f; addr = a; wdata = wd;
        @(negedge clk);
        req_valid = 1'b0;
        is_store = $urandom_range(1); funct3 = 3'($urandom); addr = $urandom; wdata = $urandom;

        if (illegal || mis) begin
            check("no_dmem_req", 32'(dmem_req), 32'd0);
            check("early_resp_valid", 32'(resp_valid), 32'd1);
            check("early_resp_err", 32'(resp_err), illegal ? 32'd3 : 32'd1);
            check("early_resp_rdata", resp_rdata, 32'd0);
        end else begin
            for (int cyc = 1; cyc <= TO + 1; cyc++) begin
                check("dmem_req_high", 32'(dmem_req), 32'd1);
                check("resp_valid_low", 32'(resp_valid), 32'd0);
                check("dmem_addr", dmem_addr, a & 32'hFFFF_FFFC);
                check("dmem_be", 32'(dmem_be), exp_be);
                check("dmem_we", 32'(dmem_we), 32'(st));
                if (st) check("dmem_wdata", dmem_wdata, exp_wd);
                dmem_ack   = (cyc == ack_cyc);
                dmem_err   = (cyc == err_cyc);
                dmem_rdata = (cyc == ack_cyc) ? rd : $urandom;
                @(negedge clk);
                dmem_ack = 1'b0;
                dmem_err = 1'b0;
                if (cyc == term) break;
                if (cyc == TO + 1) check("termination_bound", 32'(cyc), 32'(term));
            end
            check("dmem_req_dropped", 32'(dmem_req), 32'd0);
            check("resp_valid", 32'(resp_valid), 32'd1);
            check("resp_err", 32'(resp_err), fault ? 32'd2 : 32'd0);
            check("resp_rdata", resp_rdata, (fault || st) ? 32'd0 : exp_rd);
        end

        exp_err = resp_err;
        req_valid = 1'b1;
        dmem_ack  = $urandom_range(1);
        dmem_err  = $urandom_range(1);
        @(negedge clk);
        req_valid = 1'b0;
        dmem_ack  = 1'b0;
        dmem_err  = 1'b0;
        check("resp_one_cycle", 32'(resp_valid), 32'd0);
        check("no_accept_in_resp", 32'(req_ready), 32'd1);
        check("dmem_req_idle", 32'(dmem_req), 32'd0);
        check("resp_err_held", 32'(resp_err), 32'(exp_err));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; is_store = 1'b0; funct3 = 3'd0;
        addr = 32'd0; wdata = 32'd0; dmem_ack = 1'b0; dmem_rdata = 32'd0; dmem_err = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_dmem_req", 32'(dmem_req), 32'd0);
        check("rst_dmem_we", 32'(dmem_we), 32'd0);
        check("rst_dmem_be", 32'(dmem_be), 32'd0);
        check("rst_dmem_addr", dmem_addr, 32'd0);
        check("rst_dmem_wdata", dmem_wdata, 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        rst = 1'b0;

        do_req(1'b0, 3'd0, 32'h103, 32'h0, 32'h80FF_1234, 1, 0);
        do_req(1'b1, 3'd1, 32'h202, 32'h0000_ABCD, 32'h0, 1, 0);
        do_req(1'b0, 3'd2, 32'h006, 32'h0, 32'h0, 1, 0);
        do_req(1'b0, 3'd7, 32'h100, 32'h0, 32'h0, 1, 0);
        do_req(1'b0, 3'd2, 32'h040, 32'h0, 32'h1234_5678, 0, 0);
        do_req(1'b0, 3'd2, 32'h040, 32'h0, 32'h1234_5678, TO, 0);
        do_req(1'b0, 3'd2, 32'h040, 32'h0, 32'h1234_5678, 2, 2);
        do_req(1'b0, 3'd5, 32'h002, 32'h0, 32'hFEDC_1234, 4, 0);
        do_req(1'b1, 3'd3, 32'h000, 32'h0, 32'h0, 1, 0);
        do_req(1'b1, 3'd2, 32'h001, 32'h0, 32'h0, 1, 0);

        // Reset asserted in the second ACCESS cycle of an LHU
        @(negedge clk);
        req_valid = 1'b1; is_store = 1'b0; funct3 = 3'd5; addr = 32'h2; wdata = 32'h0;
        @(negedge clk);
        req_valid = 1'b0;
        check("rstacc_req_c1", 32'(dmem_req), 32'd1);
        @(negedge clk);
        check("rstacc_req_c2", 32'(dmem_req), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstacc_req_dropped", 32'(dmem_req), 32'd0);
        check("rstacc_no_resp", 32'(resp_valid), 32'd0);
        check("rstacc_ready", 32'(req_ready), 32'd1);
        dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        dmem_ack = 1'b0;
        check("late_ack_no_resp", 32'(resp_valid), 32'd0);
        check("late_ack_ready", 32'(req_ready), 32'd1);
        check("late_ack_rdata", resp_rdata, 32'd0);

        for (int i = 0; i < 250; i++) begin
            logic [31:0] ra;
            int          ack_c, err_c;
            ra    = $urandom;
            ack_c = ($urandom_range(7) == 0) ? 0 : int'($urandom_range(TO + 3, 1));
            err_c = ($urandom_range(5) == 0) ? int'($urandom_range(TO + 3, 1)) : 0;
            do_req(1'($urandom_range(1)), 3'($urandom), ra, $urandom, $urandom, ack_c, err_c);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter XLEN, default 32, data/address width; only 32 is supported.
REQ-002 Parameter TIMEOUT, default 16, maximum dmem_req cycles before an access fault (range 2..255).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  1  core requests a load/store this cycle.
REQ-006 req_ready  output  1  LSU can accept a request (state IDLE).
REQ-007 is_store  input  1  1 = store, 0 = load.
REQ-008 funct3  input  3  RV32I width code (LB=0, LH=1, LW=2, LBU=4, LHU=5; SB=0, SH=1, SW=2).
REQ-009 addr  input  XLEN  effective byte address, taken from the ALU result.
REQ-010 wdata  input  XLEN  store data (rs2).
REQ-011 resp_valid  output  1  one-cycle response pulse.
REQ-012 resp_rdata  output  XLEN  formatted load data; 0 for stores and errors.
REQ-013 resp_err  output  2  00 ok, 01 misaligned, 10 access fault, 11 illegal funct3.
REQ-014 dmem_req  output  1  memory request, held high until terminated.
REQ-015 dmem_we  output  1  write enable.
REQ-016 dmem_addr  output  XLEN  word address, equal to {addr[31:2], 2'b00}.
REQ-017 dmem_be  output  4  byte-lane enables.
REQ-018 dmem_wdata  output  XLEN  lane-replicated store data.
REQ-019 dmem_ack  input  1  memory completes the access; sampled only while dmem_req is high.
REQ-020 dmem_rdata  input  XLEN  read word; valid with dmem_ack.
REQ-021 dmem_err  input  1  bus error; sampled only while dmem_req is high.

Function
REQ-022 The FSM SHALL have states IDLE, ACCESS and RESP; req_ready = (state == IDLE).
- A request is accepted at the edge where req_valid && req_ready is true.
- At acceptance, is_store, funct3, addr and wdata are registered; later changes to these inputs are ignored.
REQ-023 Illegal funct3: loads 3, 6, 7; stores 3 to 7.
- IDLE -> RESP with resp_err = 11.
- No dmem_req is issued.
REQ-024 Misaligned access: H/HU/SH with addr[0] = 1, or W/SW with addr[1:0] != 0.
- IDLE -> RESP with resp_err = 01.
- No dmem_req is issued.
- Illegal funct3 takes priority over misalignment.
REQ-025 Otherwise, IDLE -> ACCESS.
- dmem_req, dmem_we, dmem_addr, dmem_be and dmem_wdata are registered outputs.
- They are valid from the first ACCESS cycle and held stable until termination.
REQ-026 Byte enables:
- SB: dmem_be = 4'b0001 << addr[1:0].
- SH: dmem_be = 4'b0011 << addr[1:0].
- SW: dmem_be = 4'b1111.
- Loads drive the same lane masks.
REQ-027 Store data:
- SB: dmem_wdata = {4{wdata[7:0]}}.
- SH: dmem_wdata = {2{wdata[15:0]}}.
- SW: dmem_wdata = wdata.
REQ-028 Load formatting:
- Select the byte or halfword of dmem_rdata at offset addr[1:0].
- Sign-extend for LB/LH; zero-extend for LBU/LHU.
- Register the result into resp_rdata.
REQ-029 Cycle counter:
- cnt = 0 on entering ACCESS.
- cnt increments each ACCESS cycle without termination.
REQ-030 ACCESS termination, in priority order:
- dmem_err -> RESP with resp_err = 10.
- else dmem_ack -> RESP with resp_err = 00.
- else cnt == TIMEOUT-1 -> RESP with resp_err = 10.
REQ-031 dmem_req SHALL deassert at the edge that leaves ACCESS; dmem_ack or dmem_err seen outside ACCESS is ignored.
REQ-032 RESP lasts exactly one cycle with resp_valid = 1, then returns to IDLE.
- req_valid during RESP is not accepted.
REQ-033 Latency with zero-wait memory (ack in the first ACCESS cycle): resp_valid two cycles after acceptance.
- Illegal or misaligned requests: resp_valid one cycle after acceptance.
REQ-034 resp_rdata and resp_err SHALL hold their value outside RESP; resp_rdata = 0 for stores and errors.

Reset
REQ-035 While rst is high at a clock edge, the LSU SHALL enter IDLE with:
- dmem_req = 0, dmem_we = 0, dmem_be = 0, dmem_addr = 0, dmem_wdata = 0.
- resp_valid = 0, resp_rdata = 0, resp_err = 00, cnt = 0.
REQ-036 Reset during ACCESS SHALL drop dmem_req at that edge and produce no response; a late dmem_ack is ignored.

Verification
REQ-037 Bench SHALL cover:
- LB at addr 0x103, dmem_rdata 0x80FF_1234, ack in cycle 1 -> resp_rdata 0xFFFF_FF80, err 00, resp_valid 2 cycles after acceptance.
- SH at addr 0x202 with wdata 0x0000_ABCD -> dmem_addr 0x200, dmem_be 1100, dmem_wdata 0xABCD_ABCD, dmem_we 1; resp_rdata 0.
- LW at addr 0x006 -> no dmem_req, resp err 01 one cycle later; then funct3 = 7 load -> err 11.
- LW with no ack, TIMEOUT = 16 -> dmem_req high exactly 16 cycles, then resp err 10; an ack in cycle 16 gives err 00 instead; dmem_err together with ack -> err 10.
- LHU at addr 0x2 with memory wait 3 -> dmem_req stays high, addr/be stable, while rst is held low; a separate case asserts rst in the 2nd ACCESS cycle -> dmem_req 0 next cycle, no resp_valid, later ack ignored, req_ready 1.
